// File: rtl/line_print_arbiter_pkg.sv
// Shared types and constants for the line print arbiter.
package print_arb_pkg;

  localparam int DEFAULT_LINE_LEN = 76;
  localparam int ID_W             = 5;

  localparam logic [7:0] NL_CHAR  = 8'h0A;
  localparam logic [7:0] TAG_SEP  = ":";
  localparam logic [7:0] TAG_BASE = "a";

  typedef enum logic [2:0] {
    IDLE,
    TAG0,
    TAG1,
    STREAM,
    DRAIN,
    RULE,
    NL
  } arb_state_e;

endpackage

// File: rtl/line_print_arbiter_if.sv
// Requester, rule and output-sink handshakes of the line print arbiter.
interface line_print_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rule_req;
  logic [7:0]              rule_char;
  logic                    rule_ack;
  logic                    out_valid;
  logic [7:0]              out_data;
  logic                    out_ready;

  modport master (
    output req_valid, req_data, req_last, rule_req, rule_char, out_ready,
    input  req_ready, rule_ack, out_valid, out_data
  );

  modport slave (
    input  req_valid, req_data, req_last, rule_req, rule_char, out_ready,
    output req_ready, rule_ack, out_valid, out_data
  );

endinterface

// File: rtl/line_print_arbiter_rr.sv
// Round-robin picker: searches from one past the last granted index.
module rr_arbiter
  import print_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic [ID_W-1:0] ptr_q;

  // Find the first requesting index after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int c;
      c = int'(ptr_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any_req && req[c]) begin
        any_req   = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = ID_W'(c);
      end
    end
  end

  // Remember the last winner so the next search starts just after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ptr_q <= ID_W'(NUM_REQ - 1);
    else if (advance && any_req) ptr_q <= grant_idx;
  end

endmodule

// File: rtl/line_print_arbiter.sv
// Merges per-requester character lines into one tagged, width-limited
// output stream, with optional full-width rule lines.
module line_print_arbiter
  import print_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LINE_LEN = DEFAULT_LINE_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  line_print_arbiter_if.slave bus,
  output logic [ID_W-1:0]     grant_id,
  output logic                trunc_pulse
);

  localparam int            CW       = $clog2(LINE_LEN + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);

  arb_state_e         state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [NUM_REQ-1:0] oh_q, oh_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [7:0]         rchar_q, rchar_d;
  logic               rule_q, rule_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               advance;

  logic               g_valid, g_last;
  logic [7:0]         g_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .advance   (advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Select the granted requester's character lane.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh_q[i]) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i];
      end
    end
  end

  // The index is only meaningful while a requester line is in flight.
  assign grant_id = (state_q == IDLE || rule_q) ? '0 : gid_q;

  // State register and per-line bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      oh_q    <= '0;
      gid_q   <= '0;
      rchar_q <= '0;
      rule_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      oh_q    <= oh_d;
      gid_q   <= gid_d;
      rchar_q <= rchar_d;
      rule_q  <= rule_d;
    end
  end

  // Next-state logic and all handshake outputs, decoded from the state.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    oh_d          = oh_q;
    gid_d         = gid_q;
    rchar_d       = rchar_q;
    rule_d        = rule_q;
    advance       = 1'b0;
    trunc_pulse   = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.req_ready = '0;
    bus.rule_ack  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rule_req) begin
          state_d = RULE;
          rchar_d = bus.rule_char;
          rule_d  = 1'b1;
          col_d   = '0;
        end else if (arb_any) begin
          state_d = TAG0;
          oh_d    = arb_grant;
          gid_d   = arb_idx;
          advance = 1'b1;
          col_d   = '0;
        end
      end
      TAG0: begin
        bus.out_valid = 1'b1;
        bus.out_data  = TAG_BASE + {3'b000, gid_q};
        if (bus.out_ready) begin
          col_d   = col_q + CW'(1);
          state_d = TAG1;
        end
      end
      TAG1: begin
        bus.out_valid = 1'b1;
        bus.out_data  = TAG_SEP;
        if (bus.out_ready) begin
          col_d   = col_q + CW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        bus.out_valid = g_valid;
        bus.out_data  = g_data;
        bus.req_ready = oh_q & {NUM_REQ{bus.out_ready}};
        if (g_valid && bus.out_ready) begin
          col_d = col_q + CW'(1);
          if (g_last) begin
            state_d = NL;
          end else if (col_q == LAST_COL) begin
            state_d     = DRAIN;
            trunc_pulse = 1'b1;
          end
        end
      end
      DRAIN: begin
        bus.req_ready = oh_q;
        if (g_valid && g_last) state_d = NL;
      end
      RULE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = rchar_q;
        if (bus.out_ready) begin
          col_d = col_q + CW'(1);
          if (col_q == LAST_COL) state_d = NL;
        end
      end
      NL: begin
        bus.out_valid = 1'b1;
        bus.out_data  = NL_CHAR;
        if (bus.out_ready) begin
          bus.rule_ack = rule_q;
          rule_d       = 1'b0;
          col_d        = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_print_arbiter.sv
// Directed bench for line_print_arbiter: per-requester character FIFOs
// drive the requesters, and a monitor collects the accepted output stream.
module tb_line_print_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] grant_id;
  logic       trunc_pulse;

  line_print_arbiter_if #(.NUM_REQ(4)) bus ();

  line_print_arbiter #(.NUM_REQ(4), .LINE_LEN(76)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .trunc_pulse (trunc_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] mem [4][256];
  int         head [4];
  int         tail [4];
  logic       rnd_mode = 1'b0;

  logic [7:0] got[$];
  int         nl_cnt = 0, trunc_cnt = 0, ack_cnt = 0;
  int         stall_viol = 0, ready_viol = 0;
  int         got_mark, nl_mark, trunc_mark, ack_mark;

  // Monitor at the falling edge, then drive requesters just after the rising edge.
  always begin
    logic [3:0] acc;
    logic [3:0] vld, lst, one;
    logic [3:0][7:0] dat;
    logic [8:0] ent;
    logic       stalled;
    logic [7:0] stall_data;
    @(negedge clk);
    acc = '0;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        if (bus.out_data == 8'h0A) nl_cnt++;
      end
      if (stalled && bus.out_valid && bus.out_data != stall_data) stall_viol++;
      stalled    = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (trunc_pulse) trunc_cnt++;
      if (bus.rule_ack) ack_cnt++;
      one = 4'(1) << grant_id;
      if (bus.req_ready != 4'b0 && bus.req_ready != one) ready_viol++;
      acc = bus.req_valid & bus.req_ready;
    end else begin
      stalled = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) head[i]++;
      ent    = mem[i][head[i] & 255];
      vld[i] = (head[i] != tail[i]);
      lst[i] = ent[8];
      dat[i] = ent[7:0];
    end
    bus.req_valid = vld;
    bus.req_last  = lst;
    bus.req_data  = dat;
    bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string tag, input string observed, input string expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got '%s' expected '%s'", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input string s);
    for (int k = 0; k < s.len(); k++) begin
      mem[r][tail[r] & 255] = {(k == s.len() - 1), s[k]};
      tail[r]++;
    end
  endtask

  function automatic string render(input int from);
    string s = "";
    for (int k = from; k < got.size(); k++) begin
      if (got[k] == 8'h0A) s = {s, "\\n"};
      else                 s = $sformatf("%s%c", s, got[k]);
    end
    return s;
  endfunction

  function automatic string pat(input int n);
    string s = "";
    for (int k = 0; k < n; k++) s = $sformatf("%s%c", s, 8'(48 + k % 10));
    return s;
  endfunction

  task automatic startMarks();
    got_mark   = got.size();
    nl_mark    = nl_cnt;
    trunc_mark = trunc_cnt;
    ack_mark   = ack_cnt;
  endtask

  task automatic waitLines(input string tag, input int n, input int budget);
    int k = 0;
    while (nl_cnt - nl_mark < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
      if (bus.rule_req && ack_cnt != ack_mark) bus.rule_req = 1'b0;
    end
    checkOutput({tag, "_done"}, (nl_cnt - nl_mark >= n) ? "yes" : "no", "yes");
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) tail[i] = head[i];
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    startMarks();
  endtask

  initial begin
    int k;
    rst_n         = 1'b0;
    bus.rule_req  = 1'b0;
    bus.rule_char = 8'h00;

    // Reset state, with requester 1 already presenting a line.
    repeat (3) @(posedge clk);
    #2 applyStimulus(1, "hi");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", $sformatf("%0d", bus.out_valid), "0");
    checkOutput("rst_out_data", $sformatf("%0d", bus.out_data), "0");
    checkOutput("rst_req_ready", $sformatf("%0d", bus.req_ready), "0");
    checkOutput("rst_grant_id", $sformatf("%0d", grant_id), "0");
    checkOutput("rst_pulses", $sformatf("%0d%0d", bus.rule_ack, trunc_pulse), "00");
    startMarks();
    #1 rst_n = 1'b1;

    // Simple tagged line.
    waitLines("hi", 1, 200);
    checkOutput("hi_stream", render(got_mark), "b:hi\\n");
    checkOutput("hi_trunc", $sformatf("%0d", trunc_cnt - trunc_mark), "0");

    // Two requesters alternate in round-robin order from reset.
    pulseReset();
    applyStimulus(0, "AA"); applyStimulus(0, "CC");
    applyStimulus(2, "BB"); applyStimulus(2, "DD");
    waitLines("rr", 4, 400);
    checkOutput("rr_stream", render(got_mark), "a:AA\\nc:BB\\na:CC\\nc:DD\\n");

    // Over-long line is truncated and the remainder drained.
    startMarks();
    applyStimulus(0, pat(80));
    waitLines("trunc", 1, 400);
    checkOutput("trunc_stream", render(got_mark), {"a:", pat(74), "\\n"});
    checkOutput("trunc_pulse", $sformatf("%0d", trunc_cnt - trunc_mark), "1");
    checkOutput("trunc_drained", $sformatf("%0d", tail[0] - head[0]), "0");

    // Exact fit ends normally without a truncation pulse.
    startMarks();
    applyStimulus(1, pat(74));
    waitLines("fit", 1, 400);
    checkOutput("fit_stream", render(got_mark), {"b:", pat(74), "\\n"});
    checkOutput("fit_trunc", $sformatf("%0d", trunc_cnt - trunc_mark), "0");

    // Rule line wins over a pending requester.
    startMarks();
    bus.rule_char = "-";
    bus.rule_req  = 1'b1;
    applyStimulus(3, "ok");
    waitLines("rule", 2, 600);
    checkOutput("rule_stream", render(got_mark), {{76{"-"}}, "\\nd:ok\\n"});
    checkOutput("rule_ack", $sformatf("%0d", ack_cnt - ack_mark), "1");

    // Random back-pressure on the sink.
    startMarks();
    k = stall_viol;
    rnd_mode = 1'b1;
    applyStimulus(2, "hello world");
    waitLines("stall", 1, 600);
    rnd_mode = 1'b0;
    checkOutput("stall_stream", render(got_mark), "c:hello world\\n");
    checkOutput("stall_stable", $sformatf("%0d", stall_viol - k), "0");

    // Reset in the middle of a line, then arbitration restarts at requester 0.
    startMarks();
    applyStimulus(0, pat(20));
    k = 0;
    while (got.size() - got_mark < 4 && k < 100) begin
      @(posedge clk);
      #2 k++;
    end
    checkOutput("mid_started", (got.size() - got_mark >= 4) ? "yes" : "no", "yes");
    @(negedge clk);
    #3 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) tail[i] = head[i];
    #1;
    checkOutput("mid_out_valid", $sformatf("%0d", bus.out_valid), "0");
    checkOutput("mid_out_data", $sformatf("%0d", bus.out_data), "0");
    checkOutput("mid_req_ready", $sformatf("%0d", bus.req_ready), "0");
    checkOutput("mid_grant_id", $sformatf("%0d", grant_id), "0");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    startMarks();
    applyStimulus(0, "q");
    applyStimulus(1, "r");
    waitLines("restart", 2, 200);
    checkOutput("restart_stream", render(got_mark), "a:q\\nb:r\\n");

    checkOutput("ready_onehot", $sformatf("%0d", ready_viol), "0");
    checkOutput("stall_all", $sformatf("%0d", stall_viol), "0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
